// File: rtl/pipe_stage_reg.sv
// Reusable pipeline-stage register with payload valid, flush, bubble insertion
// and saturating stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned STALL_W     = 6,
  parameter int unsigned STAGE_IDX   = 1,
  parameter int unsigned BUBBLE_ZERO = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_flushed,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  if (STALL_W < 2 || STAGE_IDX > STALL_W - 2) begin : g_bad_stage_idx
    $error("pipe_stage_reg: STAGE_IDX out of range 0..STALL_W-2");
  end

  logic up;
  logic dn;
  logic bubble_ev;
  logic hold_ev;

  always_comb begin
    up        = stall[STAGE_IDX];
    dn        = stall[STAGE_IDX+1];
    bubble_ev = flush | (up & ~dn);
    hold_ev   = ~flush & up & dn;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_flushed <= 1'b0;
    end else begin
      out_flushed <= flush;
      if (bubble_ev) begin
        out_valid <= 1'b0;
        if (BUBBLE_ZERO != 0) begin
          out_data <= '0;
        end
      end else if (!up) begin
        out_valid <= in_valid;
        out_data  <= in_data;
      end
    end
  end

  // Clear has priority over a same-cycle event; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (hold_ev && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (bubble_ev && bubble_cnt != '1) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (default, BUBBLE_ZERO=0,
// CNT_W=4) share one stimulus stream and are checked against hand values.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic        cnt_clr;

  logic        a_valid, b_valid, c_valid;
  logic [63:0] a_data, b_data, c_data;
  logic        a_fl, b_fl, c_fl;
  logic [15:0] a_scnt, a_bcnt, b_scnt, b_bcnt;
  logic [3:0]  c_scnt, c_bcnt;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] DA = 64'h0040_0000_2008_0005;
  localparam logic [63:0] DB = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] DC = 64'h0F0F_0000_AAAA_5555;
  localparam logic [63:0] DD = 64'hDEAD_BEEF_0000_0001;

  pipe_stage_reg #(.DATA_W(64), .STALL_W(6), .STAGE_IDX(1), .BUBBLE_ZERO(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(a_valid), .out_data(a_data), .out_flushed(a_fl), .cnt_clr(cnt_clr),
    .stall_cnt(a_scnt), .bubble_cnt(a_bcnt));

  pipe_stage_reg #(.DATA_W(64), .STALL_W(6), .STAGE_IDX(1), .BUBBLE_ZERO(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(b_valid), .out_data(b_data), .out_flushed(b_fl), .cnt_clr(cnt_clr),
    .stall_cnt(b_scnt), .bubble_cnt(b_bcnt));

  pipe_stage_reg #(.DATA_W(64), .STALL_W(6), .STAGE_IDX(1), .BUBBLE_ZERO(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(c_valid), .out_data(c_data), .out_flushed(c_fl), .cnt_clr(cnt_clr),
    .stall_cnt(c_scnt), .bubble_cnt(c_bcnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [63:0] d, input logic f,
                       input logic [15:0] sc, input logic [15:0] bc);
    chk({tag, ".a_valid"}, {63'd0, a_valid}, {63'd0, v});
    chk({tag, ".a_data"}, a_data, d);
    chk({tag, ".a_flushed"}, {63'd0, a_fl}, {63'd0, f});
    chk({tag, ".a_stall_cnt"}, {48'd0, a_scnt}, {48'd0, sc});
    chk({tag, ".a_bubble_cnt"}, {48'd0, a_bcnt}, {48'd0, bc});
  endtask

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0; in_valid = 1'b0; in_data = '0; cnt_clr = 1'b0;

    // 1. reset for 3 cycles, then load
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_a("reset", 1'b0, 64'd0, 1'b0, 16'd0, 16'd0);
    end
    chk("reset.c_data", c_data, 64'd0);
    rst = 1'b1; in_valid = 1'b1; in_data = DA;
    cyc();
    chk_a("load", 1'b1, DA, 1'b0, 16'd0, 16'd0);
    chk("load.b_data", b_data, DA);

    // 2. hold for 3 cycles, then one bubble
    in_data = DB; stall = 6'b000110;
    for (int i = 0; i < 3; i++) cyc();
    chk_a("hold", 1'b1, DA, 1'b0, 16'd3, 16'd0);
    chk("hold.c_stall_cnt", {60'd0, c_scnt}, 64'd3);
    stall = 6'b000010;
    cyc();
    chk_a("bubble", 1'b0, 64'd0, 1'b0, 16'd3, 16'd1);
    chk("bubble.b_data", b_data, DA);
    chk("bubble.b_valid", {63'd0, b_valid}, 64'd0);

    // 3. flush overrides hold
    stall = 6'b000110; flush = 1'b1;
    cyc();
    chk_a("flush", 1'b0, 64'd0, 1'b1, 16'd3, 16'd2);
    chk("flush.b_data", b_data, DA);
    chk("flush.b_flushed", {63'd0, b_fl}, 64'd1);
    cyc();
    chk_a("flush2", 1'b0, 64'd0, 1'b1, 16'd3, 16'd3);
    flush = 1'b0; stall = 6'b000000; in_data = DB;
    cyc();
    chk_a("after_flush", 1'b1, DB, 1'b0, 16'd3, 16'd3);
    chk("after_flush.b_data", b_data, DB);

    // load ignores dn
    stall = 6'b000100; in_data = DC;
    cyc();
    chk_a("load_dn", 1'b1, DC, 1'b0, 16'd3, 16'd3);

    // 4. saturation and clear
    stall = 6'b000110;
    for (int i = 0; i < 20; i++) cyc();
    chk("sat.c_stall_cnt", {60'd0, c_scnt}, 64'd15);
    chk("sat.a_stall_cnt", {48'd0, a_scnt}, 64'd23);
    cyc();
    chk("sat_stay.c_stall_cnt", {60'd0, c_scnt}, 64'd15);
    cnt_clr = 1'b1;
    cyc();
    chk_a("clr", 1'b1, DC, 1'b0, 16'd0, 16'd0);
    chk("clr.c_stall_cnt", {60'd0, c_scnt}, 64'd0);
    cnt_clr = 1'b0;
    cyc();
    chk_a("post_clr", 1'b1, DC, 1'b0, 16'd1, 16'd0);

    // 5. async reset between edges during a hold
    #2 rst = 1'b0;
    #1;
    chk_a("async_rst", 1'b0, 64'd0, 1'b0, 16'd0, 16'd0);
    chk("async_rst.c_stall_cnt", {60'd0, c_scnt}, 64'd0);
    cyc();
    rst = 1'b1; stall = 6'b000000; in_valid = 1'b1; in_data = DC;
    cyc();
    chk_a("post_rst_load", 1'b1, DC, 1'b0, 16'd0, 16'd0);

    // 6. invalid payload still captures data
    in_valid = 1'b0; in_data = DD;
    cyc();
    chk_a("invalid", 1'b0, DD, 1'b0, 16'd0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register for the 5-stage MIPS core. It generalises the IF/ID-style latch into one reusable block for IF/ID, ID/EX, EX/MEM and MEM/WB. It adds:
- a payload valid bit
- an explicit flush input
- a selectable bubble data mode
- saturating stall and bubble event counters for performance debug

It takes its hold/bubble decision from the shared ctrl stall vector.

Parameters:
DATA_W, 64, payload width in bits (for example pc + inst = 64 at IF/ID).
STALL_W, 6, width of the ctrl stall vector.
STAGE_IDX, 1, index of the upstream stall bit; the downstream bit is STAGE_IDX+1. Legal range is 0..STALL_W-2, checked at elaboration.
BUBBLE_ZERO, 1, bubble data mode: 1 = out_data forced to 0 on a bubble/flush; 0 = out_data keeps its old value and only out_valid drops.
CNT_W, 16, width of each performance counter.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset; 0 = reset asserted
stall  input  STALL_W  ctrl stall vector; a bit value of 1 = Stop
flush  input  1  synchronous flush of this stage (branch/exception kill)
in_valid  input  1  upstream payload valid
in_data  input  DATA_W  upstream payload
out_valid  output  1  registered payload valid
out_data  output  DATA_W  registered payload
out_flushed  output  1  one-cycle pulse, high the cycle after a flush was taken
cnt_clr  input  1  synchronous clear of both counters
stall_cnt  output  CNT_W  count of hold cycles, saturating
bubble_cnt  output  CNT_W  count of bubble/flush insertions, saturating

Behaviour:
- Definitions: up = stall[STAGE_IDX], dn = stall[STAGE_IDX+1].
- Reset (rst=0, asynchronous, takes effect immediately, even mid-stall or mid-flush): out_valid=0, out_data=0, out_flushed=0, stall_cnt=0, bubble_cnt=0.
- Each rising edge with rst=1 takes exactly one action, in this priority order:
  1. flush=1: out_valid<=0; out_data<=0 if BUBBLE_ZERO=1, else hold; out_flushed<=1; bubble_cnt increments. Flush overrides every stall combination.
  2. up=1, dn=0 (bubble): out_valid<=0; out_data as in flush; bubble_cnt increments; out_flushed<=0.
  3. up=0 (load): out_valid<=in_valid; out_data<=in_data; out_flushed<=0. The value of dn is ignored in this case.
  4. up=1, dn=1 (hold): out_valid and out_data unchanged; stall_cnt increments; out_flushed<=0.
- Latency: in_data to out_data is 1 cycle; there is no combinational path from inputs to outputs.
- Payload loaded with in_valid=0 propagates as invalid; data is still captured.
- Counters:
  - Increment by 1 per qualifying cycle.
  - Saturate at 2^CNT_W-1; they never wrap.
  - When cnt_clr=1, both counters become 0 that cycle, even if an event also occurs that cycle (clear wins).
  - Reset clears both counters.
- out_flushed is high for exactly one cycle per flush cycle. Back-to-back flushes keep it high continuously.
- All outputs are registers.

Test Plan:
1. Reset/load: rst=0 for 3 cycles, then rst=1 with stall=0, in_valid=1, in_data=64'h0040_0000_2008_0005. Required: all outputs are 0 during reset; out_data equals in_data with out_valid=1 one cycle after release.
2. Hold vs bubble (STAGE_IDX=1):
   - stall=6'b000110 for 3 cycles: outputs unchanged and stall_cnt=3.
   - then stall=6'b000010 for 1 cycle: out_valid=0, out_data=0, bubble_cnt=1.
3. Flush priority:
   - flush=1 together with stall=6'b000110: out_valid=0 and out_flushed=1 for exactly 1 cycle; stall_cnt unchanged; bubble_cnt increments by 1.
   - with BUBBLE_ZERO=0 instead: out_data keeps its previous value.
4. Saturation/clear:
   - CNT_W=4, hold for 20 cycles: stall_cnt=15 and stays at 15.
   - cnt_clr=1 together with a hold cycle: stall_cnt=0 on the next cycle.
5. Async reset mid-operation: drop rst between clock edges during a hold. Required: outputs and counters go to 0 before the next clk edge; the first edge after release with stall=0 loads in_data.
6. Invalid propagation: stall=0, in_valid=0, in_data=64'hDEAD_BEEF_0000_0001. Required: out_valid=0 and out_data=64'hDEAD_BEEF_0000_0001 after 1 cycle.
